// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a host byte stream little-endian into words
// and writes them to consecutive addresses. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int PC_WIDTH          = 19,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          base_addr,
  input  logic [PC_WIDTH-1:0]          word_count,
  input  logic                         abort,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic                         byte_ready,
  output logic                         mem_we,
  output logic [PC_WIDTH-1:0]          mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  output logic                         fetch_hold,
  output logic                         busy,
  output logic                         done,
  output logic [PC_WIDTH-1:0]          loaded_words,
  output logic [INSTRUCTION_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                         state;
  state_t                         next_state;
  logic [PC_WIDTH-1:0]            base_q;
  logic [PC_WIDTH-1:0]            count_q;
  logic [1:0]                     byte_idx;
  logic [23:0]                    partial;
  logic                           start_acc;
  logic                           accept;
  logic                           word_done;
  logic                           last_word;
  logic [INSTRUCTION_WIDTH-1:0]   new_word;

  assign start_acc = start && (state != LOAD);
  // abort wins over a byte arriving in the same cycle; the partial word is dropped
  assign accept    = (state == LOAD) && byte_valid && !abort;
  assign word_done = accept && (byte_idx == 2'd3);
  assign last_word = word_done && ((loaded_words + PC_WIDTH'(1)) == count_q);
  assign new_word  = INSTRUCTION_WIDTH'({byte_data, partial});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = (word_count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (abort)          next_state = IDLE;
        else if (last_word) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // fetch stays stalled through the final write cycle, after busy has dropped
  assign fetch_hold = busy | mem_we;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q       <= '0;
      count_q      <= '0;
      byte_idx     <= '0;
      partial      <= '0;
      loaded_words <= '0;
    end else if (start_acc) begin
      base_q       <= base_addr;
      count_q      <= word_count;
      byte_idx     <= '0;
      loaded_words <= '0;
    end else if (state == LOAD && abort) begin
      byte_idx <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    partial[7:0]   <= byte_data;
        2'd1:    partial[15:8]  <= byte_data;
        2'd2:    partial[23:16] <= byte_data;
        default: loaded_words   <= loaded_words + PC_WIDTH'(1);
      endcase
    end
  end

  // Registered write port; address wraps modulo 2^PC_WIDTH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= word_done;
      if (word_done) begin
        mem_addr  <= base_q + loaded_words;
        mem_wdata <= new_word;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INSTRUCTION_WIDTH-1:0] csum_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         csum_q <= '0;
    else if (start_acc) csum_q <= '0;
    else if (word_done) csum_q <= csum_q ^ new_word;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven main load plus hand-written
// sequences for reset, valid gaps, address wrap, empty load and abort.
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [18:0] base_addr;
  logic [18:0] word_count;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        fetch_hold;
  logic        busy;
  logic        done;
  logic [18:0] loaded_words;
  logic [31:0] checksum;

  int checks   = 0;
  int failures = 0;

  logic [18:0] wq_addr [$];
  logic [31:0] wq_data [$];
  logic [7:0]  pat [0:7];

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  typedef struct packed {
    logic        start;
    logic [18:0] base;
    logic [18:0] cnt;
    logic        valid;
    logic [7:0]  data;
    logic        e_we;
    logic [18:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_busy;
    logic        e_done;
    logic        e_hold;
    logic [18:0] e_loaded;
  } vec_t;

  vec_t tbl [0:10];

  imem_loader #(.PC_WIDTH(19), .INSTRUCTION_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fetch_hold(fetch_hold),
    .busy(busy), .done(done), .loaded_words(loaded_words), .checksum(checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
  endtask

  task automatic do_start(input logic [18:0] b, input logic [18:0] c);
    wq_addr.delete();
    wq_data.delete();
    start = 1'b1; base_addr = b; word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit gap, input string tag);
    if (gap) begin
      byte_valid = 1'b0;
      check({tag, "_ready_gap"}, 32'(byte_ready), 32'd1);
      tick();
    end
    byte_valid = 1'b1; byte_data = d;
    if (gap) check({tag, "_ready_byte"}, 32'(byte_ready), 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(busy),         32'd0);
    check({tag, "_done"},   32'(done),         32'd0);
    check({tag, "_ready"},  32'(byte_ready),   32'd0);
    check({tag, "_we"},     32'(mem_we),       32'd0);
    check({tag, "_hold"},   32'(fetch_hold),   32'd0);
    check({tag, "_addr"},   32'(mem_addr),     32'd0);
    check({tag, "_wdata"},  mem_wdata,         32'd0);
    check({tag, "_loaded"}, 32'(loaded_words), 32'd0);
    check({tag, "_csum"},   checksum,          32'd0);
  endtask

  initial begin
    pat[0] = 8'h14; pat[1] = 8'h00; pat[2] = 8'h80; pat[3] = 8'h11;
    pat[4] = 8'h01; pat[5] = 8'h02; pat[6] = 8'h03; pat[7] = 8'h04;

    //          start base    cnt     vld data   we  addr    wdata         busy done hold loaded
    tbl[0]  = '{1'b1, 19'h2, 19'h2, 1'b0, 8'h00, 1'b0, 19'h0, 32'h00000000, 1'b1, 1'b0, 1'b1, 19'h0};
    tbl[1]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'h14, 1'b0, 19'h0, 32'h00000000, 1'b1, 1'b0, 1'b1, 19'h0};
    tbl[2]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'h00, 1'b0, 19'h0, 32'h00000000, 1'b1, 1'b0, 1'b1, 19'h0};
    tbl[3]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'h80, 1'b0, 19'h0, 32'h00000000, 1'b1, 1'b0, 1'b1, 19'h0};
    tbl[4]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'h11, 1'b1, 19'h2, 32'h11800014, 1'b1, 1'b0, 1'b1, 19'h1};
    tbl[5]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'h01, 1'b0, 19'h2, 32'h11800014, 1'b1, 1'b0, 1'b1, 19'h1};
    tbl[6]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'h02, 1'b0, 19'h2, 32'h11800014, 1'b1, 1'b0, 1'b1, 19'h1};
    tbl[7]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'h03, 1'b0, 19'h2, 32'h11800014, 1'b1, 1'b0, 1'b1, 19'h1};
    tbl[8]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'h04, 1'b1, 19'h3, 32'h04030201, 1'b0, 1'b1, 1'b1, 19'h2};
    tbl[9]  = '{1'b0, 19'h0, 19'h0, 1'b1, 8'hFF, 1'b0, 19'h3, 32'h04030201, 1'b0, 1'b1, 1'b0, 19'h2};
    tbl[10] = '{1'b0, 19'h0, 19'h0, 1'b0, 8'h00, 1'b0, 19'h3, 32'h04030201, 1'b0, 1'b1, 1'b0, 19'h2};

    reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    abort = 1'b0; byte_valid = 1'b0; byte_data = '0;
    #12;
    check_reset_outputs("por");
    @(negedge clock);
    reset = 1'b1;

    // Two-word load, bytes back to back
    for (int i = 0; i <= 10; i++) begin
      start = tbl[i].start; base_addr = tbl[i].base; word_count = tbl[i].cnt;
      byte_valid = tbl[i].valid; byte_data = tbl[i].data;
      tick();
      check($sformatf("v%0d_we", i),     32'(mem_we),       32'(tbl[i].e_we));
      check($sformatf("v%0d_addr", i),   32'(mem_addr),     32'(tbl[i].e_addr));
      check($sformatf("v%0d_wdata", i),  mem_wdata,         tbl[i].e_wdata);
      check($sformatf("v%0d_busy", i),   32'(busy),         32'(tbl[i].e_busy));
      check($sformatf("v%0d_ready", i),  32'(byte_ready),   32'(tbl[i].e_busy));
      check($sformatf("v%0d_done", i),   32'(done),         32'(tbl[i].e_done));
      check($sformatf("v%0d_hold", i),   32'(fetch_hold),   32'(tbl[i].e_hold));
      check($sformatf("v%0d_loaded", i), 32'(loaded_words), 32'(tbl[i].e_loaded));
    end
    start = 1'b0; byte_valid = 1'b0;
    check("b2b_csum", checksum, CS_EN ? 32'h15830215 : 32'h0);

    // Same load with byte_valid low every other cycle
    do_start(19'h2, 19'h2);
    for (int i = 0; i < 8; i++) send(pat[i], 1'b1, $sformatf("tog%0d", i));
    tick();
    check("tog_nwrites", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      check("tog_addr0",  32'(wq_addr[0]), 32'h2);
      check("tog_data0",  wq_data[0],      32'h11800014);
      check("tog_addr1",  32'(wq_addr[1]), 32'h3);
      check("tog_data1",  wq_data[1],      32'h04030201);
    end
    check("tog_done",   32'(done),         32'd1);
    check("tog_loaded", 32'(loaded_words), 32'd2);

    // Address wrap past all-ones
    do_start(19'h7FFFF, 19'h2);
    for (int i = 0; i < 8; i++) send(pat[i], 1'b0, "wrap");
    tick();
    check("wrap_nwrites", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      check("wrap_addr0", 32'(wq_addr[0]), 32'h7FFFF);
      check("wrap_addr1", 32'(wq_addr[1]), 32'h00000);
    end

    // Empty load goes straight to DONE
    do_start(19'h5, 19'h0);
    check("zero_done",  32'(done),       32'd1);
    check("zero_busy",  32'(busy),       32'd0);
    check("zero_hold",  32'(fetch_hold), 32'd0);
    check("zero_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1; byte_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("zero_hold_%0d", i), 32'(fetch_hold), 32'd0);
    end
    byte_valid = 1'b0;
    check("zero_nwrites", 32'(wq_addr.size()), 32'd0);

    // Abort after six bytes of a two-word load
    do_start(19'h20, 19'h2);
    for (int i = 0; i < 6; i++) send(pat[i], 1'b0, "abt");
    abort = 1'b1; byte_valid = 1'b1; byte_data = pat[6];
    tick();
    abort = 1'b0; byte_valid = 1'b0;
    check("abt_busy",  32'(busy),       32'd0);
    check("abt_done",  32'(done),       32'd0);
    check("abt_ready", 32'(byte_ready), 32'd0);
    check("abt_csum",  checksum,        CS_EN ? 32'h11800014 : 32'h0);
    byte_valid = 1'b1; byte_data = pat[7];
    tick(); tick();
    byte_valid = 1'b0;
    check("abt_we",      32'(mem_we),          32'd0);
    check("abt_nwrites", 32'(wq_addr.size()),  32'd1);
    if (wq_addr.size() == 1) begin
      check("abt_addr0", 32'(wq_addr[0]), 32'h20);
      check("abt_data0", wq_data[0],      32'h11800014);
    end

    // Asynchronous reset in the middle of a load, then a clean one-word load
    do_start(19'h40, 19'h2);
    send(8'hDE, 1'b0, "mid");
    send(8'hAD, 1'b0, "mid");
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    reset = 1'b1;
    do_start(19'h10, 19'h1);
    for (int i = 0; i < 4; i++) send(pat[i], 1'b0, "post");
    check("post_done", 32'(done), 32'd1);
    tick();
    check("post_nwrites", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() == 1) begin
      check("post_addr", 32'(wq_addr[0]), 32'h10);
      check("post_data", wq_data[0],      32'h11800014);
    end
    check("post_loaded", 32'(loaded_words), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
